cache_ctrl_mp: RTL and testbench

//  Multi-port successor of the single-requester cache controller: arbitrates NUM_PORTS CPU request

---
 rtl/cache_pkg.sv | 49 ++++
 rtl/cache_rr_arbiter.sv | 41 ++++
 rtl/cache_ctrl_mp.sv | 290 +++++++++++++++++++++++++++++
 tb/tb_cache_ctrl_mp.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_pkg.sv
// ----------------------------------------------------------------------------
// cache_pkg
// Shared types and helpers for the multi-port cache controller.
//   line_state_e : encoded line states (I, UD, UC, SD, SC)
//   cpu_op_e     : CPU request opcodes (READ, WRITE, CLEAN, NOP)
//   ctrl_state_e : controller FSM states
//   is_dirty()   : line holds data newer than memory (UD or SD)
//   clean_of()   : state a dirty line takes after a clean writeback
// ----------------------------------------------------------------------------
package cache_pkg;

    typedef enum logic [2:0] {
        LS_I  = 3'b000,
        LS_UD = 3'b001,
        LS_UC = 3'b010,
        LS_SD = 3'b011,
        LS_SC = 3'b100
    } line_state_e;

    typedef enum logic [1:0] {
        OP_READ  = 2'b00,
        OP_WRITE = 2'b01,
        OP_CLEAN = 2'b10,
        OP_NOP   = 2'b11
    } cpu_op_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOOKUP,
        S_EVICT,
        S_FILL,
        S_UPGRADE,
        S_UPDATE,
        S_RESP
    } ctrl_state_e;

    function automatic logic is_dirty(input line_state_e s);
        return (s == LS_UD) || (s == LS_SD);
    endfunction

    function automatic line_state_e clean_of(input line_state_e s);
        case (s)
            LS_UD:   return LS_UC;
            LS_SD:   return LS_SC;
            default: return s;
        endcase
    endfunction

endpackage

// File: rtl/cache_rr_arbiter.sv
// ----------------------------------------------------------------------------
// cache_rr_arbiter
// Round-robin pick among NUM_PORTS requesters. The search starts at rr_ptr
// and walks upward with wrap; the first requesting port wins.
// Ports:
//   req         in  NUM_PORTS  request vector
//   rr_ptr      in  PORT_W     highest-priority port this cycle
//   grant       out NUM_PORTS  one-hot winner (all zero if no request)
//   grant_idx   out PORT_W     index of the winner
//   grant_valid out 1          some port won
// ----------------------------------------------------------------------------
module cache_rr_arbiter #(
    parameter int NUM_PORTS = 2,
    parameter int PORT_W    = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
    input  logic [NUM_PORTS-1:0] req,
    input  logic [PORT_W-1:0]    rr_ptr,
    output logic [NUM_PORTS-1:0] grant,
    output logic [PORT_W-1:0]    grant_idx,
    output logic                 grant_valid
);

    // NOTE: every output gets a default before the search loop so no path
    // through the block leaves a value unassigned (no latch is inferred).
    always_comb begin
        int idx;
        grant       = '0;
        grant_idx   = '0;
        grant_valid = 1'b0;
        idx         = 0;
        for (int off = 0; off < NUM_PORTS; off++) begin
            idx = (int'(rr_ptr) + off) % NUM_PORTS;
            if (!grant_valid && req[idx]) begin
                grant[idx]  = 1'b1;
                grant_idx   = PORT_W'(idx);
                grant_valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/cache_ctrl_mp.sv
// ----------------------------------------------------------------------------
// cache_ctrl_mp
// Multi-port cache-line transaction sequencer. Arbitrates CPU request
// channels round-robin, looks the line up, then runs the needed ACE steps
// (dirty-victim writeback, fill, shared-to-unique upgrade) before writing
// the new line state and signalling completion. Every ACE wait is bounded
// by TIMEOUT_CYCLES (0 disables the bound).
// Ports:
//   clk, reset (sync, active-high)
//   cpu_req_valid/op in, cpu_req_ready out    CPU request channels
//   cache_hit, line_state in, lookup_en out   tag/state array lookup
//   ace_ready, ace_shared in                  ACE response side
//   read_req, write_req, invalid_req out      ACE requests (level, per state)
//   write_from_cpu, write_from_interconnect   data-array write pulses
//   new_state, state_sel out                  state-array write
//   grant_id, cache_ready, cache_complete, cache_error out  status
// ----------------------------------------------------------------------------
module cache_ctrl_mp
    import cache_pkg::*;
#(
    parameter  int NUM_PORTS      = 2,
    parameter  int STATE_W        = 3,
    parameter  int TIMEOUT_CYCLES = 256,
    localparam int PORT_W         = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NUM_PORTS-1:0]   cpu_req_valid,
    input  logic [2*NUM_PORTS-1:0] cpu_req_op,
    output logic [NUM_PORTS-1:0]   cpu_req_ready,
    input  logic                   cache_hit,
    input  logic [STATE_W-1:0]     line_state,
    input  logic                   ace_ready,
    input  logic                   ace_shared,
    output logic                   lookup_en,
    output logic [PORT_W-1:0]      grant_id,
    output logic                   read_req,
    output logic                   write_req,
    output logic                   invalid_req,
    output logic                   write_from_cpu,
    output logic                   write_from_interconnect,
    output logic [STATE_W-1:0]     new_state,
    output logic                   state_sel,
    output logic                   cache_ready,
    output logic                   cache_complete,
    output logic                   cache_error
);

    localparam bit TMO_EN = (TIMEOUT_CYCLES != 0);
    localparam int TMO_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TMO_EN ? TIMEOUT_CYCLES - 1 : 0);

    ctrl_state_e         state;
    cpu_op_e             op_q;
    line_state_e         ls_q;
    logic [PORT_W-1:0]   rr_ptr;
    logic [TMO_W-1:0]    tmo_cnt;

    logic [NUM_PORTS-1:0] op_req;
    logic [NUM_PORTS-1:0] arb_req;
    logic [NUM_PORTS-1:0] arb_grant;
    logic [PORT_W-1:0]    arb_idx;
    logic                 arb_valid;
    cpu_op_e              granted_op;
    line_state_e          ls;
    logic                 hit_ok;
    logic                 tmo_expired;

    // Real operations win arbitration over NOPs; a NOP is only granted when
    // no port has real work pending.
    always_comb begin
        op_req = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            op_req[i] = cpu_req_valid[i] && (cpu_req_op[2*i +: 2] != OP_NOP);
        end
        arb_req = (|op_req) ? op_req : cpu_req_valid;
    end

    cache_rr_arbiter #(
        .NUM_PORTS (NUM_PORTS),
        .PORT_W    (PORT_W)
    ) u_arb (
        .req         (arb_req),
        .rr_ptr      (rr_ptr),
        .grant       (arb_grant),
        .grant_idx   (arb_idx),
        .grant_valid (arb_valid)
    );

    always_comb begin
        granted_op = cpu_op_e'(cpu_req_op[2*int'(arb_idx) +: 2]);
    end

    // Encodings 101..111 (and anything wider) collapse to I.
    always_comb begin
        ls = LS_I;
        if      (line_state == STATE_W'(LS_UD)) ls = LS_UD;
        else if (line_state == STATE_W'(LS_UC)) ls = LS_UC;
        else if (line_state == STATE_W'(LS_SD)) ls = LS_SD;
        else if (line_state == STATE_W'(LS_SC)) ls = LS_SC;
    end

    // A tag match on an invalid line is handled as a miss.
    assign hit_ok      = cache_hit && (ls != LS_I);
    assign tmo_expired = TMO_EN && (tmo_cnt == TMO_LAST);

    // The accept strobe must be combinational so the requester sees it in
    // the same cycle it is granted.
    assign cpu_req_ready = (state == S_IDLE && !reset) ? arb_grant : '0;

    // NOTE: outputs are assigned together with the transition into the state
    // they belong to, so they come straight from flops and line up with that
    // state's cycle; anything not set in a branch falls back to 0.
    always_ff @(posedge clk) begin
        if (reset) begin
            state                   <= S_IDLE;
            op_q                    <= OP_NOP;
            ls_q                    <= LS_I;
            rr_ptr                  <= '0;
            tmo_cnt                 <= '0;
            grant_id                <= '0;
            lookup_en               <= 1'b0;
            read_req                <= 1'b0;
            write_req               <= 1'b0;
            invalid_req             <= 1'b0;
            write_from_cpu          <= 1'b0;
            write_from_interconnect <= 1'b0;
            new_state               <= '0;
            state_sel               <= 1'b0;
            cache_ready             <= 1'b1;
            cache_complete          <= 1'b0;
            cache_error             <= 1'b0;
        end else begin
            lookup_en               <= 1'b0;
            read_req                <= 1'b0;
            write_req               <= 1'b0;
            invalid_req             <= 1'b0;
            write_from_cpu          <= 1'b0;
            write_from_interconnect <= 1'b0;
            new_state               <= '0;
            state_sel               <= 1'b0;
            cache_ready             <= 1'b0;
            cache_complete          <= 1'b0;
            cache_error             <= 1'b0;

            unique case (state)
                S_IDLE: begin
                    if (arb_valid) begin
                        grant_id <= arb_idx;
                        op_q     <= granted_op;
                        rr_ptr   <= (arb_idx == PORT_W'(NUM_PORTS - 1)) ? '0
                                                                        : arb_idx + PORT_W'(1);
                        if (granted_op == OP_NOP) begin
                            state          <= S_RESP;
                            cache_complete <= 1'b1;
                        end else begin
                            state     <= S_LOOKUP;
                            lookup_en <= 1'b1;
                        end
                    end else begin
                        cache_ready <= 1'b1;
                    end
                end

                S_LOOKUP: begin
                    ls_q    <= ls;
                    tmo_cnt <= '0;
                    unique case (op_q)
                        OP_READ: begin
                            if (hit_ok) begin
                                state          <= S_RESP;
                                cache_complete <= 1'b1;
                            end else if (is_dirty(ls)) begin
                                state     <= S_EVICT;
                                write_req <= 1'b1;
                            end else begin
                                state    <= S_FILL;
                                read_req <= 1'b1;
                            end
                        end
                        OP_WRITE: begin
                            if (hit_ok && (ls == LS_UC || ls == LS_UD)) begin
                                state          <= S_UPDATE;
                                state_sel      <= 1'b1;
                                new_state      <= STATE_W'(LS_UD);
                                write_from_cpu <= 1'b1;
                            end else if (hit_ok) begin
                                state       <= S_UPGRADE;
                                invalid_req <= 1'b1;
                            end else if (is_dirty(ls)) begin
                                state     <= S_EVICT;
                                write_req <= 1'b1;
                            end else begin
                                state    <= S_FILL;
                                read_req <= 1'b1;
                            end
                        end
                        OP_CLEAN: begin
                            if (hit_ok && is_dirty(ls)) begin
                                state     <= S_EVICT;
                                write_req <= 1'b1;
                            end else begin
                                state          <= S_RESP;
                                cache_complete <= 1'b1;
                            end
                        end
                        default: begin
                            state          <= S_RESP;
                            cache_complete <= 1'b1;
                        end
                    endcase
                end

                S_EVICT: begin
                    if (ace_ready) begin
                        tmo_cnt <= '0;
                        if (op_q == OP_CLEAN) begin
                            state     <= S_UPDATE;
                            state_sel <= 1'b1;
                            new_state <= STATE_W'(clean_of(ls_q));
                        end else begin
                            state    <= S_FILL;
                            read_req <= 1'b1;
                        end
                    end else if (tmo_expired) begin
                        state          <= S_RESP;
                        cache_complete <= 1'b1;
                        cache_error    <= 1'b1;
                    end else begin
                        write_req <= 1'b1;
                        if (TMO_EN) tmo_cnt <= tmo_cnt + TMO_W'(1);
                    end
                end

                S_FILL: begin
                    if (ace_ready) begin
                        state                   <= S_UPDATE;
                        state_sel               <= 1'b1;
                        write_from_interconnect <= 1'b1;
                        if (op_q == OP_WRITE) begin
                            new_state      <= STATE_W'(LS_UD);
                            write_from_cpu <= 1'b1;
                        end else begin
                            new_state <= ace_shared ? STATE_W'(LS_SC) : STATE_W'(LS_UC);
                        end
                    end else if (tmo_expired) begin
                        state          <= S_RESP;
                        cache_complete <= 1'b1;
                        cache_error    <= 1'b1;
                    end else begin
                        read_req <= 1'b1;
                        if (TMO_EN) tmo_cnt <= tmo_cnt + TMO_W'(1);
                    end
                end

                S_UPGRADE: begin
                    if (ace_ready) begin
                        state          <= S_UPDATE;
                        state_sel      <= 1'b1;
                        new_state      <= STATE_W'(LS_UD);
                        write_from_cpu <= 1'b1;
                    end else if (tmo_expired) begin
                        state          <= S_RESP;
                        cache_complete <= 1'b1;
                        cache_error    <= 1'b1;
                    end else begin
                        invalid_req <= 1'b1;
                        if (TMO_EN) tmo_cnt <= tmo_cnt + TMO_W'(1);
                    end
                end

                S_UPDATE: begin
                    state          <= S_RESP;
                    cache_complete <= 1'b1;
                end

                S_RESP: begin
                    state       <= S_IDLE;
                    cache_ready <= 1'b1;
                end

                default: begin
                    state       <= S_IDLE;
                    cache_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cache_ctrl_mp.sv
// ----------------------------------------------------------------------------
// tb_cache_ctrl_mp
// Directed, cycle-scripted bench for cache_ctrl_mp (2 ports, timeout 8).
// Inputs are driven 1 time unit after the rising edge; registered outputs
// are sampled there too; the combinational accept strobe is sampled 1 unit
// later, once the freshly driven request has propagated.
// ----------------------------------------------------------------------------
module tb_cache_ctrl_mp;

    localparam int NP  = 2;
    localparam int SW  = 3;
    localparam int TMO = 8;

    localparam logic [1:0] OP_RD = 2'b00;
    localparam logic [1:0] OP_WR = 2'b01;
    localparam logic [1:0] OP_CL = 2'b10;
    localparam logic [1:0] OP_NP = 2'b11;

    localparam logic [2:0] ST_I  = 3'b000;
    localparam logic [2:0] ST_UD = 3'b001;
    localparam logic [2:0] ST_UC = 3'b010;
    localparam logic [2:0] ST_SD = 3'b011;
    localparam logic [2:0] ST_SC = 3'b100;

    logic            clk = 1'b0;
    logic            reset;
    logic [NP-1:0]   cpu_req_valid;
    logic [2*NP-1:0] cpu_req_op;
    logic [NP-1:0]   cpu_req_ready;
    logic            cache_hit;
    logic [SW-1:0]   line_state;
    logic            ace_ready;
    logic            ace_shared;
    logic            lookup_en;
    logic            grant_id;
    logic            read_req;
    logic            write_req;
    logic            invalid_req;
    logic            write_from_cpu;
    logic            write_from_interconnect;
    logic [SW-1:0]   new_state;
    logic            state_sel;
    logic            cache_ready;
    logic            cache_complete;
    logic            cache_error;

    int checks = 0;
    int errors = 0;

    // Pulse counters, sampled mid-cycle.
    int n_sel = 0;
    int n_cmp = 0;
    int n_rd  = 0;
    int n_inv = 0;

    always #5 clk = ~clk;

    cache_ctrl_mp #(
        .NUM_PORTS      (NP),
        .STATE_W        (SW),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk                     (clk),
        .reset                   (reset),
        .cpu_req_valid           (cpu_req_valid),
        .cpu_req_op              (cpu_req_op),
        .cpu_req_ready           (cpu_req_ready),
        .cache_hit               (cache_hit),
        .line_state              (line_state),
        .ace_ready               (ace_ready),
        .ace_shared              (ace_shared),
        .lookup_en               (lookup_en),
        .grant_id                (grant_id),
        .read_req                (read_req),
        .write_req               (write_req),
        .invalid_req             (invalid_req),
        .write_from_cpu          (write_from_cpu),
        .write_from_interconnect (write_from_interconnect),
        .new_state               (new_state),
        .state_sel               (state_sel),
        .cache_ready             (cache_ready),
        .cache_complete          (cache_complete),
        .cache_error             (cache_error)
    );

    always @(negedge clk) begin
        if (state_sel)      n_sel <= n_sel + 1;
        if (cache_complete) n_cmp <= n_cmp + 1;
        if (read_req)       n_rd  <= n_rd + 1;
        if (invalid_req)    n_inv <= n_inv + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Raise a request on one port and check the accept strobe this cycle.
    task automatic request(input int port, input logic [1:0] op, input string tag);
        cpu_req_valid[port]       = 1'b1;
        cpu_req_op[2*port +: 2]   = op;
        #1;
        check({tag, ".ready"}, 32'(cpu_req_ready), 32'(1 << port));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int s_sel, s_cmp, s_rd, s_inv;
        reset         = 1'b1;
        cpu_req_valid = '0;
        cpu_req_op    = '0;
        cache_hit     = 1'b0;
        line_state    = ST_I;
        ace_ready     = 1'b0;
        ace_shared    = 1'b0;
        repeat (3) tick();
        reset = 1'b0;
        tick();

        // Reset state
        check("rst.cache_ready", 32'(cache_ready), 1);
        check("rst.lookup_en",   32'(lookup_en),   0);
        check("rst.read_req",    32'(read_req),    0);
        check("rst.complete",    32'(cache_complete), 0);
        check("rst.state_sel",   32'(state_sel),   0);
        check("rst.grant_id",    32'(grant_id),    0);
        check("rst.ready",       32'(cpu_req_ready), 0);

        // 1: P0 READ hit on UC
        s_sel = n_sel;
        request(0, OP_RD, "t1");
        cache_hit = 1'b1; line_state = ST_UC;
        tick();
        cpu_req_valid = '0;
        check("t1.lookup_en",  32'(lookup_en), 1);
        check("t1.ready_low",  32'(cpu_req_ready), 0);
        check("t1.busy",       32'(cache_ready), 0);
        tick();
        check("t1.complete",   32'(cache_complete), 1);
        check("t1.error",      32'(cache_error), 0);
        check("t1.grant_id",   32'(grant_id), 0);
        tick();
        check("t1.idle",       32'(cache_ready), 1);
        check("t1.no_sel",     32'(n_sel - s_sel), 0);

        // 2: P1 WRITE hit on SC, ace_ready 3 cycles late
        s_inv = n_inv;
        request(1, OP_WR, "t2");
        cache_hit = 1'b1; line_state = ST_SC;
        tick();
        cpu_req_valid = '0;
        for (int k = 1; k <= 4; k++) begin
            tick();
            if (k == 1) line_state = ST_UC;   // ignored outside LOOKUP
            check($sformatf("t2.inv_req%0d", k), 32'(invalid_req), 1);
            ace_ready = (k == 4);
        end
        tick();
        ace_ready = 1'b0;
        check("t2.state_sel",  32'(state_sel), 1);
        check("t2.new_state",  32'(new_state), 32'(ST_UD));
        check("t2.wr_cpu",     32'(write_from_cpu), 1);
        check("t2.wr_ic",      32'(write_from_interconnect), 0);
        check("t2.inv_done",   32'(invalid_req), 0);
        tick();
        check("t2.complete",   32'(cache_complete), 1);
        check("t2.grant_id",   32'(grant_id), 1);
        check("t2.inv_cycles", 32'(n_inv - s_inv), 4);
        tick();

        // 3: P0 WRITE miss, victim SD -> writeback, fill, update
        request(0, OP_WR, "t3");
        cache_hit = 1'b0; line_state = ST_SD;
        tick();
        cpu_req_valid = '0;
        tick();
        check("t3.wb1",        32'(write_req), 1);
        check("t3.rd_off1",    32'(read_req), 0);
        tick();
        check("t3.wb2",        32'(write_req), 1);
        ace_ready = 1'b1; ace_shared = 1'b1;
        tick();
        check("t3.fill",       32'(read_req), 1);
        check("t3.wb_off",     32'(write_req), 0);
        tick();
        ace_ready = 1'b0; ace_shared = 1'b0;
        check("t3.state_sel",  32'(state_sel), 1);
        check("t3.new_state",  32'(new_state), 32'(ST_UD));
        check("t3.wr_cpu",     32'(write_from_cpu), 1);
        check("t3.wr_ic",      32'(write_from_interconnect), 1);
        check("t3.rd_off",     32'(read_req), 0);
        tick();
        check("t3.complete",   32'(cache_complete), 1);
        check("t3.error",      32'(cache_error), 0);
        tick();

        // 5: READ miss, ace_ready never comes -> timeout after 8 cycles
        // 5b: same, ace_ready on the 8th cycle -> success, shared fill
        for (int b = 0; b < 2; b++) begin
            s_sel = n_sel; s_rd = n_rd;
            request(0, OP_RD, $sformatf("t5_%0d", b));
            cache_hit = 1'b0; line_state = ST_UC;
            tick();
            cpu_req_valid = '0;
            for (int k = 1; k <= TMO; k++) begin
                tick();
                check($sformatf("t5_%0d.rd%0d", b, k), 32'(read_req), 1);
                ace_ready  = (b == 1) && (k == TMO);
                ace_shared = (b == 1);
            end
            tick();
            ace_ready = 1'b0; ace_shared = 1'b0;
            if (b == 0) begin
                check("t5.complete",  32'(cache_complete), 1);
                check("t5.error",     32'(cache_error), 1);
                check("t5.rd_off",    32'(read_req), 0);
            end else begin
                check("t5b.state_sel", 32'(state_sel), 1);
                check("t5b.new_state", 32'(new_state), 32'(ST_SC));
                check("t5b.wr_ic",     32'(write_from_interconnect), 1);
                check("t5b.wr_cpu",    32'(write_from_cpu), 0);
                tick();
                check("t5b.complete",  32'(cache_complete), 1);
                check("t5b.error",     32'(cache_error), 0);
            end
            check($sformatf("t5_%0d.rd_cycles", b), 32'(n_rd - s_rd), 8);
            check($sformatf("t5_%0d.sel_cnt", b), 32'(n_sel - s_sel), 32'(b));
            tick();
        end

        // 6: reset during FILL abandons the transaction
        s_cmp = n_cmp;
        request(0, OP_RD, "t6");
        cache_hit = 1'b0; line_state = ST_I;
        tick();
        cpu_req_valid = '0;
        tick();
        check("t6.fill", 32'(read_req), 1);
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("t6.rd_drop",     32'(read_req), 0);
        check("t6.cache_ready", 32'(cache_ready), 1);
        repeat (4) tick();
        check("t6.no_complete", 32'(n_cmp - s_cmp), 0);

        // 4: both ports always valid -> grants 0,1,0,1
        cpu_req_valid = 2'b11;
        cpu_req_op    = {OP_RD, OP_RD};
        cache_hit     = 1'b1;
        line_state    = ST_UC;
        for (int t = 0; t < 4; t++) begin
            #1;
            check($sformatf("t4.ready%0d", t), 32'(cpu_req_ready), 32'(1 << (t % 2)));
            tick();
            tick();
            check($sformatf("t4.complete%0d", t), 32'(cache_complete), 1);
            check($sformatf("t4.grant_id%0d", t), 32'(grant_id), 32'(t % 2));
            tick();
        end
        cpu_req_valid = '0;

        // NOP-only request goes straight to RESP
        request(1, OP_NP, "tn");
        tick();
        cpu_req_valid = '0;
        check("tn.complete",  32'(cache_complete), 1);
        check("tn.no_lookup", 32'(lookup_en), 0);
        check("tn.grant_id",  32'(grant_id), 1);
        tick();

        // CLEAN hit on UD -> writeback then UD->UC
        request(0, OP_CL, "tc");
        cache_hit = 1'b1; line_state = ST_UD;
        tick();
        cpu_req_valid = '0;
        ace_ready = 1'b1;
        tick();
        check("tc.wb",        32'(write_req), 1);
        tick();
        ace_ready = 1'b0;
        check("tc.state_sel", 32'(state_sel), 1);
        check("tc.new_state", 32'(new_state), 32'(ST_UC));
        check("tc.wr_cpu",    32'(write_from_cpu), 0);
        check("tc.wr_ic",     32'(write_from_interconnect), 0);
        tick();
        check("tc.complete",  32'(cache_complete), 1);
        tick();
        check("tc.idle",      32'(cache_ready), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
